// File: rtl/spi_responder_pkg.sv
// Shared constants, state encoding and helpers for the SPI mode-0 responder.
package spi_responder_pkg;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned BITCNT_W = 3;

    localparam logic [BYTE_W-1:0] IDLE_BYTE_DEFAULT = 8'hFF;

    // Mode 0: SCK idles low, data sampled on the rising edge.
    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    // MSB-first shift: the new bit enters at the LSB.
    function automatic logic [BYTE_W-1:0] shift_in(input logic [BYTE_W-1:0] s, input logic b);
        return {s[BYTE_W-2:0], b};
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronises the SPI pins into the CLK domain and extracts SCK and nSS edges.
module spi_pin_sync
    import spi_responder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sck_i,
    input  logic mosi_i,
    input  logic nss_i,
    output logic mosi_s_o,
    output logic rise_c,
    output logic fall_c,
    output logic sel_edge_c,
    output logic desel_edge_c
);

    logic [SYNC_STAGES-1:0] sck_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic [SYNC_STAGES-1:0] nss_q;
    logic                   sck_dly_q;
    logic                   nss_dly_q;

    logic sck_s;
    logic nss_s;

    assign sck_s = sck_q[SYNC_STAGES-1];
    assign nss_s = nss_q[SYNC_STAGES-1];

    // Equal depth on all three pins keeps MOSI aligned with the SCK edge that samples it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q     <= '0;
            mosi_q    <= '0;
            nss_q     <= '1;
            sck_dly_q <= 1'b0;
            nss_dly_q <= 1'b1;
        end else begin
            sck_q     <= {sck_q[SYNC_STAGES-2:0], sck_i ^ CPOL};
            mosi_q    <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
            nss_q     <= {nss_q[SYNC_STAGES-2:0], nss_i};
            sck_dly_q <= sck_s;
            nss_dly_q <= nss_s;
        end
    end

    assign mosi_s_o     = mosi_q[SYNC_STAGES-1];
    assign rise_c       = sck_s & ~sck_dly_q;
    assign fall_c       = ~sck_s & sck_dly_q;
    assign sel_edge_c   = ~nss_s & nss_dly_q;
    assign desel_edge_c = nss_s & ~nss_dly_q;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder: oversampled pins, MSB-first shift registers and
// one-entry valid/ready byte interfaces toward local logic.
module spi_responder
    import spi_responder_pkg::*;
#(
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [BYTE_W-1:0] IDLE_BYTE   = IDLE_BYTE_DEFAULT
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic              SCK,
    input  logic              MOSI,
    input  logic              nSS,
    output logic              MISO,
    output logic              MISO_OE,
    input  logic [BYTE_W-1:0] TXDATA,
    input  logic              TXVALID,
    output logic              TXREADY,
    output logic [BYTE_W-1:0] RXDATA,
    output logic              RXVALID,
    input  logic              RXREADY,
    output logic              SELECTED,
    output logic              ABORT,
    output logic              OVERRUN,
    output logic              UNDERRUN,
    input  logic              CLRFLAGS
);

    logic mosi_s;
    logic rise;
    logic fall;
    logic sel_edge;
    logic desel_edge;

    spi_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_pin_sync (
        .clk          (CLK),
        .rst_n        (nRESET),
        .sck_i        (SCK),
        .mosi_i       (MOSI),
        .nss_i        (nSS),
        .mosi_s_o     (mosi_s),
        .rise_c       (rise),
        .fall_c       (fall),
        .sel_edge_c   (sel_edge),
        .desel_edge_c (desel_edge)
    );

    state_e              state_q, state_d;
    logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
    logic                load_pending_q, load_pending_d;
    logic [BYTE_W-1:0]   tx_shift_q, tx_shift_d;
    logic [BYTE_W-1:0]   rx_shift_q, rx_shift_d;
    logic [BYTE_W-1:0]   hold_q, hold_d;
    logic                txready_q, txready_d;
    logic [BYTE_W-1:0]   rxdata_q, rxdata_d;
    logic                rxvalid_q, rxvalid_d;
    logic                miso_oe_q, miso_oe_d;
    logic                selected_q, selected_d;
    logic                abort_q, abort_d;
    logic                overrun_q, overrun_d;
    logic                underrun_q, underrun_d;

    logic              tx_load;
    logic              byte_done;
    logic [BYTE_W-1:0] rx_byte;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q        <= ST_IDLE;
            bitcnt_q       <= '0;
            load_pending_q <= 1'b0;
            tx_shift_q     <= IDLE_BYTE;
            rx_shift_q     <= '0;
            hold_q         <= '0;
            txready_q      <= 1'b1;
            rxdata_q       <= '0;
            rxvalid_q      <= 1'b0;
            miso_oe_q      <= 1'b0;
            selected_q     <= 1'b0;
            abort_q        <= 1'b0;
            overrun_q      <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            bitcnt_q       <= bitcnt_d;
            load_pending_q <= load_pending_d;
            tx_shift_q     <= tx_shift_d;
            rx_shift_q     <= rx_shift_d;
            hold_q         <= hold_d;
            txready_q      <= txready_d;
            rxdata_q       <= rxdata_d;
            rxvalid_q      <= rxvalid_d;
            miso_oe_q      <= miso_oe_d;
            selected_q     <= selected_d;
            abort_q        <= abort_d;
            overrun_q      <= overrun_d;
            underrun_q     <= underrun_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        bitcnt_d       = bitcnt_q;
        load_pending_d = load_pending_q;
        tx_shift_d     = tx_shift_q;
        rx_shift_d     = rx_shift_q;
        hold_d         = hold_q;
        txready_d      = txready_q;
        rxdata_d       = rxdata_q;
        rxvalid_d      = rxvalid_q;
        miso_oe_d      = miso_oe_q;
        selected_d     = selected_q;
        abort_d        = 1'b0;
        overrun_d      = overrun_q;
        underrun_d     = underrun_q;
        tx_load        = 1'b0;
        byte_done      = 1'b0;
        rx_byte        = shift_in(rx_shift_q, mosi_s);

        // Select/deselect edges take precedence over any SCK edge in the same cycle.
        case (state_q)
            ST_IDLE: begin
                if (sel_edge) begin
                    state_d    = ST_ACTIVE;
                    selected_d = 1'b1;
                    miso_oe_d  = 1'b1;
                    bitcnt_d   = '0;
                    tx_load    = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (desel_edge) begin
                    state_d        = ST_IDLE;
                    selected_d     = 1'b0;
                    miso_oe_d      = 1'b0;
                    load_pending_d = 1'b0;
                    bitcnt_d       = '0;
                    abort_d        = (bitcnt_q != '0);
                end else begin
                    if (rise) begin
                        rx_shift_d = rx_byte;
                        if (&bitcnt_q) begin
                            byte_done      = 1'b1;
                            load_pending_d = 1'b1;
                            bitcnt_d       = '0;
                        end else begin
                            bitcnt_d = bitcnt_q + BITCNT_W'(1);
                        end
                    end
                    if (fall) begin
                        if (load_pending_q) begin
                            tx_load        = 1'b1;
                            load_pending_d = 1'b0;
                        end else begin
                            tx_shift_d = shift_in(tx_shift_q, 1'b1);
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A load sees the hold register as it was at the start of the cycle.
        if (tx_load) begin
            if (!txready_q) begin
                tx_shift_d = hold_q;
                txready_d  = 1'b1;
            end else begin
                tx_shift_d = IDLE_BYTE;
                underrun_d = 1'b1;
            end
        end

        if (TXVALID && txready_q) begin
            hold_d    = TXDATA;
            txready_d = 1'b0;
        end

        if (byte_done) begin
            if (!rxvalid_q || RXREADY) begin
                rxdata_d  = rx_byte;
                rxvalid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (RXREADY) begin
            rxvalid_d = 1'b0;
        end

        if (CLRFLAGS) begin
            overrun_d  = 1'b0;
            underrun_d = 1'b0;
        end
    end

    assign MISO     = tx_shift_q[BYTE_W-1];
    assign MISO_OE  = miso_oe_q;
    assign TXREADY  = txready_q;
    assign RXDATA   = rxdata_q;
    assign RXVALID  = rxvalid_q;
    assign SELECTED = selected_q;
    assign ABORT    = abort_q;
    assign OVERRUN  = overrun_q;
    assign UNDERRUN = underrun_q;

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: a bit-banged mode-0 master at CLK/8 with a queue-based expectation model.
module tb_spi_responder;

    localparam int unsigned SYNC = 2;
    localparam int          HALF = 4;

    logic       clk = 1'b0;
    logic       nRESET = 1'b0;
    logic       SCK = 1'b0;
    logic       MOSI = 1'b0;
    logic       nSS = 1'b1;
    logic       MISO;
    logic       MISO_OE;
    logic [7:0] TXDATA = 8'h00;
    logic       TXVALID = 1'b0;
    logic       TXREADY;
    logic [7:0] RXDATA;
    logic       RXVALID;
    logic       RXREADY = 1'b0;
    logic       SELECTED;
    logic       ABORT;
    logic       OVERRUN;
    logic       UNDERRUN;
    logic       CLRFLAGS = 1'b0;

    int total = 0;
    int bad   = 0;

    localparam logic [15:0] RESET_VEC = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

    spi_responder #(
        .SYNC_STAGES (SYNC),
        .IDLE_BYTE   (8'hFF)
    ) dut (
        .CLK      (clk),
        .nRESET   (nRESET),
        .SCK      (SCK),
        .MOSI     (MOSI),
        .nSS      (nSS),
        .MISO     (MISO),
        .MISO_OE  (MISO_OE),
        .TXDATA   (TXDATA),
        .TXVALID  (TXVALID),
        .TXREADY  (TXREADY),
        .RXDATA   (RXDATA),
        .RXVALID  (RXVALID),
        .RXREADY  (RXREADY),
        .SELECTED (SELECTED),
        .ABORT    (ABORT),
        .OVERRUN  (OVERRUN),
        .UNDERRUN (UNDERRUN),
        .CLRFLAGS (CLRFLAGS)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    function automatic logic [15:0] status_vec();
        return {MISO, MISO_OE, TXREADY, RXVALID, SELECTED, ABORT, OVERRUN, UNDERRUN, RXDATA};
    endfunction

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        nRESET = 1'b0; SCK = 1'b0; nSS = 1'b1; MOSI = 1'b0;
        TXVALID = 1'b0; RXREADY = 1'b0; CLRFLAGS = 1'b0;
        clk_n(2);
        nRESET = 1'b1;
        clk_n(2);
    endtask

    task automatic sel();
        nSS = 1'b0;
        clk_n(SYNC + 4);
    endtask

    task automatic desel();
        nSS = 1'b1;
        clk_n(SYNC + 4);
    endtask

    task automatic tx_push(input logic [7:0] b);
        int n = 0;
        while (!TXREADY && n < 200) begin
            clk_n(1);
            n++;
        end
        if (!TXREADY) begin
            $display("FAIL tx_push_timeout: TXREADY=%b required 1", TXREADY);
            bad++;
            total++;
        end
        TXDATA  = b;
        TXVALID = 1'b1;
        clk_n(1);
        TXVALID = 1'b0;
    endtask

    // Master side: MOSI changes with the falling edge, MISO is read just before each rise.
    task automatic spi_bits(input logic [7:0] mo, input int n, input bit end_high, output logic [7:0] mi);
        logic [2:0] idx;
        mi = 8'h00;
        for (int i = 0; i < n; i++) begin
            idx = 3'(7 - i);
            MOSI = mo[idx];
            clk_n(HALF);
            mi[idx] = MISO;
            SCK = 1'b1;
            if (i != n - 1 || !end_high) begin
                clk_n(HALF);
                SCK = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        logic [15:0] v;
        clk_n(2);
        v = status_vec();
        if (v !== RESET_VEC) begin
            $display("FAIL reset_values: got %b required %b", v, RESET_VEC);
            bad++;
        end
        total++;
        nRESET = 1'b1;
        clk_n(2);
    endtask

    task automatic test_basic();
        logic [7:0] mi;
        do_reset();
        tx_push(8'hA5);
        if (TXREADY !== 1'b0) begin $display("FAIL t1_hold_full: TXREADY=%b required 0", TXREADY); bad++; end
        total++;
        sel();
        if ({SELECTED, MISO_OE, TXREADY} !== 3'b111) begin
            $display("FAIL t1_select: SELECTED/MISO_OE/TXREADY=%b required 111", {SELECTED, MISO_OE, TXREADY}); bad++;
        end
        total++;
        spi_bits(8'h3C, 8, 1'b1, mi);
        clk_n(SYNC);
        if (RXVALID !== 1'b0) begin $display("FAIL t1_rxvalid_early: RXVALID=%b required 0", RXVALID); bad++; end
        total++;
        clk_n(1);
        if ({RXVALID, RXDATA, UNDERRUN} !== {1'b1, 8'h3C, 1'b0}) begin
            $display("FAIL t1_rx: RXVALID=%b RXDATA=%h UNDERRUN=%b required 1 3c 0", RXVALID, RXDATA, UNDERRUN); bad++;
        end
        total++;
        clk_n(HALF - int'(SYNC) - 1);
        SCK = 1'b0;
        clk_n(HALF);
        if (mi !== 8'hA5) begin $display("FAIL t1_miso: got %h required a5", mi); bad++; end
        total++;
        desel();
    endtask

    task automatic test_underrun();
        logic [7:0] mi0, mi1;
        do_reset();
        sel();
        if (UNDERRUN !== 1'b1) begin $display("FAIL t2_underrun_select: UNDERRUN=%b required 1", UNDERRUN); bad++; end
        total++;
        fork
            spi_bits(8'h00, 8, 1'b0, mi0);
            begin
                clk_n(12);
                tx_push(8'h81);
            end
        join
        spi_bits(8'h00, 8, 1'b0, mi1);
        if ({mi0, mi1} !== 16'hFF81) begin $display("FAIL t2_miso: got %h required ff81", {mi0, mi1}); bad++; end
        total++;
        desel();
        if (UNDERRUN !== 1'b1) begin $display("FAIL t2_underrun_sticky: UNDERRUN=%b required 1", UNDERRUN); bad++; end
        total++;
        CLRFLAGS = 1'b1;
        clk_n(1);
        CLRFLAGS = 1'b0;
        if (UNDERRUN !== 1'b0) begin $display("FAIL t2_clrflags: UNDERRUN=%b required 0", UNDERRUN); bad++; end
        total++;
    endtask

    task automatic test_overrun();
        logic [7:0] mi;
        do_reset();
        sel();
        spi_bits(8'h11, 8, 1'b0, mi);
        spi_bits(8'h22, 8, 1'b0, mi);
        if ({RXVALID, RXDATA, OVERRUN} !== {1'b1, 8'h11, 1'b1}) begin
            $display("FAIL t3_overrun: RXVALID=%b RXDATA=%h OVERRUN=%b required 1 11 1", RXVALID, RXDATA, OVERRUN); bad++;
        end
        total++;
        CLRFLAGS = 1'b1; RXREADY = 1'b1;
        clk_n(1);
        CLRFLAGS = 1'b0; RXREADY = 1'b0;
        if ({RXVALID, OVERRUN} !== 2'b00) begin
            $display("FAIL t3_clear: RXVALID/OVERRUN=%b required 00", {RXVALID, OVERRUN}); bad++;
        end
        total++;
        spi_bits(8'h11, 8, 1'b0, mi);
        spi_bits(8'h22, 8, 1'b1, mi);
        clk_n(SYNC);
        RXREADY = 1'b1;
        clk_n(1);
        RXREADY = 1'b0;
        if ({RXVALID, RXDATA, OVERRUN} !== {1'b1, 8'h22, 1'b0}) begin
            $display("FAIL t3_accept_on_complete: RXVALID=%b RXDATA=%h OVERRUN=%b required 1 22 0", RXVALID, RXDATA, OVERRUN); bad++;
        end
        total++;
        clk_n(HALF - int'(SYNC) - 1);
        SCK = 1'b0;
        clk_n(HALF);
        desel();
    endtask

    task automatic test_abort();
        logic [7:0] mi;
        logic       exp_abort;
        do_reset();
        sel();
        spi_bits(8'h77, 8, 1'b0, mi);
        spi_bits(8'hFF, 5, 1'b0, mi);
        clk_n(4);
        nSS = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            clk_n(1);
            exp_abort = (k == int'(SYNC) + 1);
            if (ABORT !== exp_abort) begin
                $display("FAIL t4_abort_cycle%0d: ABORT=%b required %b", k, ABORT, exp_abort); bad++;
            end
            total++;
        end
        if ({MISO_OE, SELECTED, RXVALID, RXDATA} !== {1'b0, 1'b0, 1'b1, 8'h77}) begin
            $display("FAIL t4_after_abort: MISO_OE=%b SELECTED=%b RXVALID=%b RXDATA=%h required 0 0 1 77",
                     MISO_OE, SELECTED, RXVALID, RXDATA); bad++;
        end
        total++;
        RXREADY = 1'b1;
        clk_n(1);
        RXREADY = 1'b0;
        sel();
        spi_bits(8'hF0, 8, 1'b0, mi);
        if ({RXVALID, RXDATA} !== {1'b1, 8'hF0}) begin
            $display("FAIL t4_fresh_byte: RXVALID=%b RXDATA=%h required 1 f0", RXVALID, RXDATA); bad++;
        end
        total++;
        desel();
    endtask

    task automatic test_idle_sck();
        logic [7:0] mi;
        logic       seen;
        do_reset();
        tx_push(8'h3C);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            SCK  = ~SCK;
            MOSI = 1'($urandom);
            clk_n(1);
            seen = seen | ABORT | RXVALID | MISO_OE;
            clk_n(1);
            seen = seen | ABORT | RXVALID | MISO_OE;
        end
        SCK = 1'b0;
        clk_n(4);
        if ({seen, TXREADY} !== 2'b00) begin
            $display("FAIL t5_idle_sck: activity=%b TXREADY=%b required 0 0", seen, TXREADY); bad++;
        end
        total++;
        sel();
        spi_bits(8'h96, 8, 1'b0, mi);
        if ({mi, RXDATA} !== 16'h3C96) begin
            $display("FAIL t5_after_idle: miso=%h RXDATA=%h required 3c 96", mi, RXDATA); bad++;
        end
        total++;
        desel();
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0]  mi;
        logic [15:0] v;
        do_reset();
        tx_push(8'hC3);
        sel();
        tx_push(8'hE7);
        spi_bits(8'hAA, 3, 1'b0, mi);
        clk_n(2);
        nRESET = 1'b0;
        #1;
        v = status_vec();
        if (v !== RESET_VEC) begin
            $display("FAIL t6_async_reset: got %b required %b", v, RESET_VEC); bad++;
        end
        total++;
        nSS = 1'b1; SCK = 1'b0; MOSI = 1'b0;
        clk_n(2);
        nRESET = 1'b1;
        clk_n(3);
        tx_push(8'h5A);
        sel();
        spi_bits(8'h5A, 8, 1'b0, mi);
        if ({mi, RXVALID, RXDATA} !== {8'h5A, 1'b1, 8'h5A}) begin
            $display("FAIL t6_after_reset: miso=%h RXVALID=%b RXDATA=%h required 5a 1 5a", mi, RXVALID, RXDATA); bad++;
        end
        total++;
        desel();
    endtask

    // Random multi-byte frames: MISO must replay the pushed bytes in order, RXDATA each MOSI byte.
    task automatic test_random_stream();
        logic [7:0] txb[4];
        logic [7:0] mob[4];
        logic [7:0] mi;
        int         n;
        for (int r = 0; r < 4; r++) begin
            do_reset();
            n = int'($urandom_range(4, 1));
            for (int k = 0; k < 4; k++) begin
                txb[k] = 8'($urandom);
                mob[k] = 8'($urandom);
            end
            tx_push(txb[0]);
            sel();
            for (int k = 0; k < n; k++) begin
                if (k + 1 < n) tx_push(txb[k + 1]);
                spi_bits(mob[k], 8, 1'b0, mi);
                if (mi !== txb[k]) begin
                    $display("FAIL rnd_miso r%0d b%0d: got %h required %h", r, k, mi, txb[k]); bad++;
                end
                total++;
                if ({RXVALID, RXDATA} !== {1'b1, mob[k]}) begin
                    $display("FAIL rnd_rx r%0d b%0d: RXVALID=%b RXDATA=%h required 1 %h", r, k, RXVALID, RXDATA, mob[k]); bad++;
                end
                total++;
                RXREADY = 1'b1;
                clk_n(1);
                RXREADY = 1'b0;
            end
            desel();
            if ({OVERRUN, ABORT} !== 2'b00) begin
                $display("FAIL rnd_flags r%0d: OVERRUN=%b ABORT=%b required 0 0", r, OVERRUN, ABORT); bad++;
            end
            total++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_overrun();
        test_abort();
        test_idle_sck();
        test_reset_mid_byte();
        test_random_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
